seq_shift_add_multiplier: RTL and testbench

- Multi-cycle unsigned WIDTH x WIDTH multiplier: one shared adder/accumulator, sequenced by an FSM over one multiplier bit per cycle.
- Area-reduced alternative to the fully unrolled combinational multiplier. Sits between a requester (valid/ready in) and a consumer (valid/ready out).
- One operation in flight at a time.

---
 rtl/seq_shift_add_multiplier_if.sv | 29 ++
 rtl/seq_shift_add_multiplier.sv | 100 ++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_shift_add_multiplier_if
// Purpose  : Operand/product valid-ready bundle for seq_shift_add_multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   ina;
  logic [WIDTH-1:0]   inb;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;
  logic               busy;

  modport master (
    output in_valid, ina, inb, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, ina, inb, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_shift_add_multiplier
// Purpose  : Multi-cycle unsigned WIDTH x WIDTH shift-add multiplier, one
//            multiplier bit per cycle. Optional: SEQ_MULT_EARLY_TERM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  seq_shift_add_multiplier_if.slave  bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [PW-1:0]      r_acc;
  logic [PW-1:0]      r_mcand;
  logic [PW-1:0]      r_out;
  logic [PW-1:0]      w_acc_sum;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_last;

  assign w_acc_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Finish once no set bits remain above the one consumed this cycle.
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)        w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.ina};
            r_mplier <= bus.inb;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          // Product register is separate so it survives the next operation's acc clear.
          if (w_last) begin
            r_out <= w_acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign bus.out       = r_out;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_shift_add_multiplier
// Purpose  : Directed self-checking bench for seq_shift_add_multiplier (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_shift_add_multiplier;

  localparam int WIDTH = 8;
`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          cyc_et;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs [9];

  seq_shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_cyc(input int cyc_et);
    return ET ? cyc_et : WIDTH;
  endfunction

  // Accept one operation, scramble the operands afterwards, then count RUN cycles.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int cyc);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.ina      = a;
    bus.inb      = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.ina      = ~a;
    bus.inb      = ~b;
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    p = bus.out;
  endtask

  task automatic ack_and_check(input logic [15:0] p);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("out_kept_after_ack", 32'(bus.out), 32'(p));
  endtask

  initial begin
    logic [15:0] p;
    int          cyc;
    int          seen;

    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'd143,   cyc_et: 4};
    vecs[1] = '{a: 8'd255, b: 8'd255, prod: 16'hFE01,  cyc_et: 8};
    vecs[2] = '{a: 8'd0,   b: 8'd200, prod: 16'd0,     cyc_et: 8};
    vecs[3] = '{a: 8'd200, b: 8'd0,   prod: 16'd0,     cyc_et: 1};
    vecs[4] = '{a: 8'd77,  b: 8'd1,   prod: 16'd77,    cyc_et: 1};
    vecs[5] = '{a: 8'd1,   b: 8'h80,  prod: 16'd128,   cyc_et: 8};
    vecs[6] = '{a: 8'd2,   b: 8'd3,   prod: 16'd6,     cyc_et: 2};
    vecs[7] = '{a: 8'd100, b: 8'd50,  prod: 16'd5000,  cyc_et: 6};
    vecs[8] = '{a: 8'd128, b: 8'd2,   prod: 16'd256,   cyc_et: 2};

    bus.in_valid  = 1'b0;
    bus.ina       = '0;
    bus.inb       = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, p, cyc);
      chk("vec_product", 32'(p), 32'(vecs[i].prod));
      chk("vec_run_cycles", 32'(cyc), 32'(exp_cyc(vecs[i].cyc_et)));
      chk("done_busy", 32'(bus.busy), 32'd1);
      chk("done_in_ready", 32'(bus.in_ready), 32'd0);
      ack_and_check(vecs[i].prod);
    end

    // Back-pressure: product must stay put and new requests must be ignored.
    do_op(8'd7, 8'd9, p, cyc);
    chk("bp_product", 32'(p), 32'd63);
    bus.ina      = 8'd1;
    bus.inb      = 8'd1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out", 32'(bus.out), 32'd63);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    ack_and_check(16'd63);

    // in_valid held high across two operations with out_ready held.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.ina       = 8'd3;
    bus.inb       = 8'd5;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.ina = 8'd6;
    bus.inb = 8'd7;
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("held_first_cycles", 32'(cyc), 32'(exp_cyc(3)));
    chk("held_first_product", 32'(bus.out), 32'd15);
    @(posedge clk);
    #1;
    chk("held_back_to_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("held_second_accepted", 32'(bus.busy), 32'd1);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("held_second_cycles", 32'(cyc), 32'(exp_cyc(3)));
    chk("held_second_product", 32'(bus.out), 32'd42);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("held_no_duplicate", 32'(seen), 32'd0);
    bus.out_ready = 1'b0;

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus.ina      = 8'd200;
    bus.inb      = 8'd255;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_out", 32'(bus.out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("no_pulse_after_reset", 32'(seen), 32'd0);
    do_op(8'd2, 8'd3, p, cyc);
    chk("post_reset_product", 32'(p), 32'd6);
    chk("post_reset_cycles", 32'(cyc), 32'(exp_cyc(2)));
    ack_and_check(16'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
